// File: rtl/ram_xfer.sv
// Multi-beat transfer engine: serializes a DW-bit store into BW-bit beats, or
// issues read beats and assembles them little-endian with zero/sign extension.
module ram_xfer #(
  parameter int DW     = 64,
  parameter int BW     = 8,
  parameter int AW     = 16,
  parameter int RD_LAT = 1,
  localparam int N     = DW / BW,
  localparam int CW    = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          we,
  input  logic          sext,
  input  logic [CW-1:0] len,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [BW-1:0] mem_wd,
  input  logic [BW-1:0] mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_busy;
  logic              r_done;
  logic [DW-1:0]     r_q;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [AW-1:0]     r_mem_addr;
  logic [BW-1:0]     r_mem_wd;
  logic              r_sext;
  logic [AW-1:0]     r_addr;
  logic [CW-1:0]     r_len;
  logic [DW-1:0]     r_d;
  logic [CW-1:0]     r_k;
  logic [CW-1:0]     r_rk;
  logic [DW-1:0]     r_acc;
  logic [RD_LAT-1:0] r_pipe;

  logic [CW-1:0]     w_len_clamp;
  logic              w_all_issued;
  logic              w_rd_valid;
  logic              w_last_cap;
  logic              w_sign;
  logic [DW-1:0]     w_acc_next;
  logic [DW-1:0]     w_q_next;

  assign w_len_clamp  = (len > CW'(N)) ? CW'(N) : len;
  assign w_all_issued = (r_k == r_len);
  // r_pipe[i] marks a read issued i+1 cycles ago; the top bit means mem_rd is live now.
  assign w_rd_valid   = r_pipe[RD_LAT-1];
  assign w_last_cap   = w_rd_valid && (r_rk == r_len - CW'(1));
  // The final beat is always the one arriving on the capture edge, so its MSB is the sign.
  assign w_sign       = r_sext & mem_rd[BW-1];

  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < N; j++) begin
      if (CW'(j) == r_rk) w_acc_next[j*BW +: BW] = mem_rd;
    end
  end

  always_comb begin
    w_q_next = '0;
    for (int j = 0; j < N; j++) begin
      if (CW'(j) < r_len) w_q_next[j*BW +: BW] = w_acc_next[j*BW +: BW];
      else                w_q_next[j*BW +: BW] = {BW{w_sign}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && w_len_clamp != '0) w_state_next = we ? S_WR : S_RD;
      S_WR:    if (w_all_issued) w_state_next = S_IDLE;
      S_RD:    if (w_all_issued) w_state_next = S_DRAIN;
      S_DRAIN: if (w_last_cap) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_q        <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      r_sext     <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_d        <= '0;
      r_k        <= '0;
      r_rk       <= '0;
      r_acc      <= '0;
      r_pipe     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_pipe[0] <= r_mem_en & ~r_mem_we;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      if (w_rd_valid) begin
        r_acc <= w_acc_next;
        r_rk  <= r_rk + CW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sext <= sext;
            r_addr <= addr;
            r_len  <= w_len_clamp;
            r_d    <= d >> BW;
            r_rk   <= '0;
            if (w_len_clamp == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy     <= 1'b1;
              r_mem_en   <= 1'b1;
              r_mem_we   <= we;
              r_mem_addr <= addr;
              if (we) r_mem_wd <= d[BW-1:0];
              r_k        <= CW'(1);
            end
          end
        end
        S_WR, S_RD: begin
          if (w_all_issued) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_state == S_WR) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end else begin
            r_mem_addr <= r_addr + AW'(r_k);
            if (r_state == S_WR) begin
              r_mem_wd <= r_d[BW-1:0];
              r_d      <= r_d >> BW;
            end
            r_k <= r_k + CW'(1);
          end
        end
        S_DRAIN: begin
          if (w_last_cap) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_q    <= w_q_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign q        = r_q;
  assign mem_en   = r_mem_en;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wd   = r_mem_wd;

endmodule

// File: tb/tb_ram_xfer.sv
// Bench for ram_xfer: table of transfers against a byte-wide RAM model, plus
// hand sequences for mid-transfer reset and back-to-back start.
module tb_ram_xfer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        we;
  logic        sext;
  logic [3:0]  len;
  logic [15:0] addr;
  logic [63:0] d;
  logic        busy;
  logic        done;
  logic [63:0] q;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_q = '0;
  logic [7:0]  mem [0:65535];
  // expected beat entries: {we, addr, wd}
  logic [24:0] exp_q[$];

  ram_xfer #(.DW(64), .BW(8), .AW(16), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .sext(sext), .len(len),
    .addr(addr), .d(d), .busy(busy), .done(done), .q(q), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Byte RAM with one cycle read latency.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rd <= mem[mem_addr];
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wd;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Beat scoreboard: every mem_en cycle must match the head of exp_q.
  always @(negedge clk) begin
    if (mem_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {39'd0, mem_we, mem_addr, mem_wd}, 64'd0);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if (e[24]) chk("store_beat", {39'd0, mem_we, mem_addr, mem_wd}, {39'd0, e});
        else       chk("load_beat", {47'd0, mem_we, mem_addr}, {47'd0, e[24:8]});
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic        sext;
    logic [3:0]  len;
    logic [15:0] addr;
    logic [63:0] d;
    logic [63:0] exp_q;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int  l;
    bit  seen;
    l = (v.len > 4'd8) ? 8 : int'(v.len);
    for (int k = 0; k < l; k++)
      exp_q.push_back({v.we, v.addr + 16'(k), v.we ? v.d[k*8 +: 8] : 8'h00});
    @(negedge clk);
    start = 1'b1; we = v.we; sext = v.sext; len = v.len; addr = v.addr; d = v.d;
    seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        chk({v.name, "_busy_c1"}, {63'd0, busy}, {63'd0, (l != 0)});
      end
      if (done) begin
        chk({v.name, "_lat"}, 64'(c), 64'(v.exp_lat));
        chk({v.name, "_busy_end"}, {63'd0, busy}, 64'd0);
        if (!v.we && l != 0) model_q = v.exp_q;
        chk({v.name, "_q"}, q, model_q);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({v.name, "_done_timeout"}, 64'd0, 64'd1);
    chk({v.name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs[10];
  int   n_done;

  initial begin
    vecs[0] = '{"st8",      1'b1, 1'b0, 4'd8,  16'h0100, 64'h8877665544332211, 64'h0, 9};
    vecs[1] = '{"ld2_sx",   1'b0, 1'b1, 4'd2,  16'h0200, 64'h0, 64'hFFFFFFFFFFFF9234, 4};
    vecs[2] = '{"ld2_zx",   1'b0, 1'b0, 4'd2,  16'h0200, 64'h0, 64'h0000000000009234, 4};
    vecs[3] = '{"st3_wrap", 1'b1, 1'b0, 4'd3,  16'hFFFE, 64'h0000000000CCBBAA, 64'h0, 4};
    vecs[4] = '{"st12",     1'b1, 1'b0, 4'd12, 16'h0300, 64'h0102030405060708, 64'h0, 9};
    vecs[5] = '{"ld12",     1'b0, 1'b1, 4'd12, 16'h0300, 64'h0, 64'h0102030405060708, 10};
    vecs[6] = '{"ld3_sx",   1'b0, 1'b1, 4'd3,  16'h0100, 64'h0, 64'h0000000000332211, 5};
    vecs[7] = '{"ld1_sx",   1'b0, 1'b1, 4'd1,  16'h0107, 64'h0, 64'hFFFFFFFFFFFFFF88, 3};
    vecs[8] = '{"len0",     1'b0, 1'b1, 4'd0,  16'h0500, 64'h0, 64'h0, 1};
    vecs[9] = '{"ld2_wrap", 1'b0, 1'b0, 4'd2,  16'hFFFF, 64'h0, 64'h000000000000CCBB, 4};

    mem[16'h0200] = 8'h34;
    mem[16'h0201] = 8'h92;
    rst = 1'b1; start = 1'b0; we = 1'b0; sext = 1'b0; len = '0; addr = '0; d = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_q", q, 64'd0);
    chk("rst_mem", {38'd0, mem_en, mem_we, mem_addr, mem_wd}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset during an 8-beat load: beats 0..3 issued, then nothing.
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 16'h0100 + 16'(k), 8'h00});
    @(negedge clk);
    start = 1'b1; we = 1'b0; sext = 1'b0; len = 4'd8; addr = 16'h0100;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 4) rst = 1'b1;
      if (c == 5) begin
        rst = 1'b0;
        chk("mrst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_q", q, 64'd0);
      end
      if (c >= 5 && done) n_done++;
    end
    chk("mrst_no_done", 64'(n_done), 64'd0);
    chk("mrst_beats_left", 64'(exp_q.size()), 64'd0);
    model_q = '0;

    // Store then load started in the store's done cycle; a start during busy is ignored.
    exp_q.push_back({1'b1, 16'h0400, 8'hEF});
    exp_q.push_back({1'b1, 16'h0401, 8'hBE});
    exp_q.push_back({1'b0, 16'h0400, 8'h00});
    exp_q.push_back({1'b0, 16'h0401, 8'h00});
    @(negedge clk);
    start = 1'b1; we = 1'b1; sext = 1'b0; len = 4'd2; addr = 16'h0400; d = 64'hBEEF;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (c == 1) start = 1'b0;
      if (c == 3) begin
        chk("b2b_store_done", {63'd0, done}, 64'd1);
        start = 1'b1; we = 1'b0; sext = 1'b0; len = 4'd2; addr = 16'h0400;
      end
      if (c == 4) begin
        start = 1'b0;
        chk("b2b_first_issue", {46'd0, mem_en, mem_we, mem_addr}, {46'd0, 1'b1, 1'b0, 16'h0400});
      end
      if (c == 5) begin
        start = 1'b1; we = 1'b1; len = 4'd8; addr = 16'h0500;
      end
      if (c == 6) start = 1'b0;
      if (c == 7) begin
        chk("b2b_load_done", {63'd0, done}, 64'd1);
        chk("b2b_load_q", q, 64'h000000000000BEEF);
      end
    end
    chk("b2b_done_count", 64'(n_done), 64'd2);
    chk("b2b_beats_left", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
